// File: rtl/scan_cmd_responder.sv
`default_nettype none
// ============================================================================
// Module   : scan_cmd_responder
// Brief    : Command-driven scan responder with capture, shift, update and
//            nop commands. Optional assertions: define SCAN_CMD_ASSERT_EN.
// Revision : 1.0  initial release
// ============================================================================
module scan_cmd_responder #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4,
  parameter int ERR_W = 8
) (
  input  logic             mclk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [WIDTH-1:0] d,
  input  logic             scan_in,
  output logic             scan_out,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic [ERR_W-1:0] err_cnt
);

  localparam logic [1:0] C_OP_CAPTURE = 2'b00;
  localparam logic [1:0] C_OP_SHIFT   = 2'b01;
  localparam logic [1:0] C_OP_UPDATE  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CAP  = 3'd1,
    S_SHF  = 3'd2,
    S_UPD  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] r_q;
  logic [ERR_W-1:0] r_err;
  logic [LEN_W-1:0] r_rem;
  logic [LEN_W-1:0] w_rem_next;
  logic [LEN_W-1:0] w_len_eff;
  logic             w_accept;

  assign w_accept  = cmd_valid && (r_state == S_IDLE);
  // Oversized shift requests are clamped so a full register is never overrun.
  assign w_len_eff = (cmd_len > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : cmd_len;

  always_comb begin
    w_next     = r_state;
    w_rem_next = r_rem;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          case (cmd_op)
            C_OP_CAPTURE: w_next = S_CAP;
            C_OP_UPDATE:  w_next = S_UPD;
            C_OP_SHIFT: begin
              if (w_len_eff != '0) begin
                w_next     = S_SHF;
                w_rem_next = w_len_eff;
              end else begin
                w_next = S_DONE;
              end
            end
            default: w_next = S_DONE;
          endcase
        end
      end
      S_CAP: w_next = S_DONE;
      S_SHF: begin
        w_rem_next = r_rem - LEN_W'(1);
        if (r_rem <= LEN_W'(1)) w_next = S_DONE;
      end
      S_UPD:   w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_rem   <= '0;
    end else begin
      r_state <= w_next;
      r_rem   <= w_rem_next;
    end
  end

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift <= '0;
      r_q     <= '0;
      r_err   <= '0;
    end else begin
      case (r_state)
        S_CAP: begin
          r_shift <= d;
          // A capture equal to the held output breaks the q != d invariant.
          if ((d == r_q) && (r_err != '1)) r_err <= r_err + ERR_W'(1);
        end
        S_SHF:   r_shift <= {scan_in, r_shift[WIDTH-1:1]};
        S_UPD:   r_q     <= r_shift;
        default: ;
      endcase
    end
  end

  assign cmd_ready = (r_state == S_IDLE);
  assign busy      = !cmd_ready;
  assign done      = (r_state == S_DONE);
  assign scan_out  = r_shift[0];
  assign q         = r_q;
  assign err_cnt   = r_err;

`ifdef SCAN_CMD_ASSERT_EN
  always @(posedge mclk) begin
    a_done_pulse: assert property (disable iff (!rst_n) done |=> !done);
    a_ready_busy: assert property (disable iff (!rst_n) !(cmd_ready && busy));
    a_rem_bound:  assert property (disable iff (!rst_n) r_rem <= LEN_W'(WIDTH));
    a_q_on_upd:   assert property (disable iff (!rst_n)
                    (q != $past(q)) |-> ($past(r_state) == S_UPD));
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_scan_cmd_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_scan_cmd_responder
// Brief    : Directed scoreboard bench for scan_cmd_responder (WIDTH=8, ERR_W=2).
// Revision : 1.0  initial release
// ============================================================================
module tb_scan_cmd_responder;

  localparam int WIDTH = 8;
  localparam int LEN_W = 4;
  localparam int ERR_W = 2;

  localparam logic [1:0] OP_CAP = 2'b00;
  localparam logic [1:0] OP_SHF = 2'b01;
  localparam logic [1:0] OP_UPD = 2'b10;
  localparam logic [1:0] OP_NOP = 2'b11;

  logic             mclk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_op = 2'b00;
  logic [LEN_W-1:0] cmd_len = '0;
  logic [WIDTH-1:0] d = '0;
  logic             scan_in = 1'b0;
  logic             scan_out;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             done;
  logic [ERR_W-1:0] err_cnt;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   lat_q[$];
  bit   sin_q[$];
  bit   sout_q[$];
  logic [WIDTH-1:0] m_q;
  int   m_err;
  logic [WIDTH-1:0] pat;

  scan_cmd_responder #(.WIDTH(WIDTH), .LEN_W(LEN_W), .ERR_W(ERR_W)) dut (
    .mclk(mclk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_len(cmd_len), .d(d), .scan_in(scan_in),
    .scan_out(scan_out), .q(q), .busy(busy), .done(done), .err_cnt(err_cnt)
  );

  always #5 mclk = ~mclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 32'(cmd_ready), 32'd1);
    check({tag, "_busy"},  32'(busy),      32'd0);
    check({tag, "_done"},  32'(done),      32'd0);
    check({tag, "_sout"},  32'(scan_out),  32'd0);
    check({tag, "_q"},     32'(q),         32'd0);
    check({tag, "_err"},   32'(err_cnt),   32'd0);
  endtask

  // Issue one command, then follow it to done, checking latency and scan bits.
  task automatic issue(input logic [1:0] op, input logic [LEN_W-1:0] len,
                       input logic [WIDTH-1:0] dv, input int lat, input bit hold);
    int n;
    int exp_lat;
    bit exp_bit;
    @(negedge mclk);
    check("ready_before", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_op = op; cmd_len = len; d = dv;
    lat_q.push_back(lat);
    @(posedge mclk);
    #1 cmd_valid = 1'b0;
    n = 0;
    forever begin
      @(negedge mclk);
      n++;
      if (done || n > 40) break;
      if (hold) begin
        cmd_valid = 1'b1;
        cmd_op    = 2'($urandom_range(0, 3));
        check("ready_busy", 32'(cmd_ready), 32'd0);
      end
      if (op == OP_SHF && sout_q.size() > 0) begin
        exp_bit = sout_q.pop_front();
        check("scan_out_bit", 32'(scan_out), 32'(exp_bit));
        scan_in = sin_q.pop_front();
      end
    end
    cmd_valid = 1'b0;
    exp_lat = lat_q.pop_front();
    check("latency", 32'(n), 32'(exp_lat));
    check("busy_in_done", 32'(busy), 32'd1);
    @(negedge mclk);
    check("done_single", 32'(done), 32'd0);
    check("ready_after", 32'(cmd_ready), 32'd1);
  endtask

  task automatic capture(input logic [WIDTH-1:0] dv);
    if (dv == m_q && m_err < 3) m_err++;
    issue(OP_CAP, '0, dv, 2, 1'b0);
    check("cap_sout", 32'(scan_out), 32'(dv[0]));
    check("cap_err", 32'(err_cnt), 32'(m_err));
  endtask

  initial begin
    m_q = '0;
    m_err = 0;
    repeat (2) @(negedge mclk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    capture(8'hA5);

    // scan_in 1,0,1,1,0,0,1,0 while A5 leaves LSB-first
    pat = 8'h4D;
    for (int i = 0; i < 8; i++) begin
      sin_q.push_back(pat[i]);
    end
    pat = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      sout_q.push_back(pat[i]);
    end
    issue(OP_SHF, 4'd8, '0, 9, 1'b0);
    issue(OP_UPD, '0, '0, 2, 1'b0);
    m_q = 8'h4D;
    check("upd_q", 32'(q), 32'(m_q));

    for (int k = 0; k < 5; k++) begin
      capture(8'h4D);
    end
    check("err_saturated", 32'(err_cnt), 32'd3);

    issue(OP_SHF, 4'd0, '0, 1, 1'b0);
    check("len0_sout", 32'(scan_out), 32'd1);

    pat = 8'h4D;
    for (int i = 0; i < 8; i++) begin
      sin_q.push_back(1'b0);
      sout_q.push_back(pat[i]);
    end
    issue(OP_SHF, 4'd15, '0, 9, 1'b0);
    check("len15_sout", 32'(scan_out), 32'd0);

    issue(OP_NOP, '0, '0, 1, 1'b0);

    for (int i = 0; i < 4; i++) begin
      sin_q.push_back(1'b1);
      sout_q.push_back(1'b0);
    end
    issue(OP_SHF, 4'd4, 8'h4D, 5, 1'b1);
    check("hold_q", 32'(q), 32'(m_q));
    check("hold_err", 32'(err_cnt), 32'd3);
    check("hold_sout", 32'(scan_out), 32'd0);

    // Reset in the third SHF cycle of an 8-bit shift.
    @(negedge mclk);
    cmd_valid = 1'b1; cmd_op = OP_SHF; cmd_len = 4'd8; scan_in = 1'b1;
    @(posedge mclk);
    #1 cmd_valid = 1'b0;
    repeat (3) @(negedge mclk);
    check("pre_reset_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    for (int i = 0; i < 3; i++) begin
      @(negedge mclk);
      check("reset_no_done", 32'(done), 32'd0);
    end
    rst_n = 1'b1;
    m_q = '0;
    m_err = 0;

    capture(8'h3C);
    issue(OP_UPD, '0, '0, 2, 1'b0);
    m_q = 8'h3C;
    check("post_reset_q", 32'(q), 32'(m_q));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/scan_cmd_responder.md
# scan_cmd_responder

Command-driven scan responder for the mission-clock domain. It accepts capture / shift / update / nop commands over a valid/ready handshake and captures functional data `d` into a shift register. The shift register moves serially between `scan_in` and `scan_out`. An update copies the shift register into the held output `q`. It also counts captures where `d == q`, which are violations of the `q != d` invariant that the assertion suites check.

## Interface
- `WIDTH`, default 8: width of `d`, `q` and the shift register (≥ 2).
- `LEN_W`, default 4: width of `cmd_len`; must satisfy 2^LEN_W > WIDTH.
- `ERR_W`, default 8: width of the violation counter.
- `mclk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `cmd_valid`, in, 1: command offered.
- `cmd_ready`, out, 1: responder idle and able to accept a command.
- `cmd_op`, in, 2: command opcode; 00 CAPTURE, 01 SHIFT, 10 UPDATE, 11 NOP.
- `cmd_len`, in, LEN_W: number of shift cycles; used by SHIFT only.
- `d`, in, WIDTH: functional data sampled on CAPTURE.
- `scan_in`, in, 1: serial input, shifted in at the MSB end.
- `scan_out`, out, 1: serial output, always equal to `shift_reg[0]`.
- `q`, out, WIDTH: update register.
- `busy`, out, 1: FSM not in IDLE.
- `done`, out, 1: one-cycle pulse when a command completes.
- `err_cnt`, out, ERR_W: saturating count of captures with `d == q`.

## Operation
- FSM states: IDLE, CAP, SHF, UPD, DONE.
- `cmd_ready = (state == IDLE)`. A command is accepted on a rising edge where `cmd_valid && cmd_ready`.
- While `cmd_ready` is 0, `cmd_valid` is ignored. The command is not queued.
- `cmd_op` and `cmd_len` are latched at accept.
- Transitions from IDLE on accept:
  - CAPTURE → CAP
  - UPDATE → UPD
  - NOP → DONE
  - SHIFT with effective length N ≥ 1 → SHF
  - SHIFT with N = 0 → DONE
- Effective shift length: `N = min(cmd_len, WIDTH)`. `cmd_len > WIDTH` is clamped to WIDTH.
- CAP, one cycle:
  - `shift_reg <= d`.
  - If `d == q` and `err_cnt` is not all-ones, `err_cnt` increments.
  - Then go to DONE.
- SHF, exactly N cycles. Each cycle: `shift_reg <= {scan_in, shift_reg[WIDTH-1:1]}`. The remaining-count register decrements; at 1, go to DONE.
- UPD, one cycle: `q <= shift_reg`, then go to DONE.
- DONE, one cycle: `done = 1`, then go to IDLE.
- `busy = !cmd_ready`.
- `err_cnt` saturates at 2^ERR_W − 1 and does not wrap.

## Timing
- Reset values: state IDLE, `cmd_ready` = 1, `busy` = 0, `done` = 0, `shift_reg` = 0, `scan_out` = 0, `q` = 0, `err_cnt` = 0, remaining count = 0.
- Latency is counted from the accept edge to the cycle in which `done` is high:
  - CAPTURE and UPDATE: 2 cycles.
  - SHIFT with N ≥ 1: N + 1 cycles.
  - SHIFT with N = 0, and NOP: 1 cycle.
- `cmd_ready` returns to 1 in the cycle after `done`.
- Back-to-back commands: minimum issue interval is latency + 1 cycles.
- `scan_out` changes only on SHF edges and on CAP edges. It is valid in the cycle before each shift edge.
- CAP compares `d` against the `q` value present before the edge.
- A reset assertion mid-command aborts the command immediately and returns all state and outputs to their reset values. No `done` pulse is produced.
- `d`, `scan_in` and `cmd_*` are synchronous to `mclk`.

## Configuration
- `SCAN_CMD_ASSERT_EN`, when defined:
  - Compiles in concurrent assertions embedded in the FSM's `always @(posedge mclk)` block. The clock is inferred from the block; reset disables them via `disable iff (!rst_n)`.
  - Checked properties:
    - `done` is never high on two consecutive cycles.
    - `cmd_ready` and `busy` are mutually exclusive.
    - The remaining shift count never exceeds WIDTH.
    - `q` changes only one cycle after UPD.
- When undefined: no assertion code is present, and the functional behaviour is identical.

## Test plan
- Reset with all outputs checked, then CAPTURE with `d = 8'hA5`, `q = 0` → `done` 2 cycles after accept, `shift_reg = 8'hA5`, `scan_out = 1`, `err_cnt = 0`.
- SHIFT with `cmd_len = 8` and `scan_in` driving 1,0,1,1,0,0,1,0 after the previous capture, then UPDATE → `scan_out` emits 1,0,1,0,0,1,0,1; `done` 9 cycles after the SHIFT accept; `q = 8'h4D`.
- CAPTURE with `d == q == 8'h4D` → `err_cnt = 1`. With `ERR_W = 2`, after 5 matching captures `err_cnt` stays at 3.
- SHIFT with `cmd_len = 0` → `done` 1 cycle after accept, `shift_reg` unchanged. SHIFT with `cmd_len = 15` (WIDTH = 8) → exactly 8 shifts, `done` after 9 cycles.
- Hold `cmd_valid` high with changing `cmd_op` during a busy SHIFT → only the accepted command executes; `cmd_ready = 0` until the cycle after `done`.
- Assert `rst_n` low in the 3rd SHF cycle → outputs return to reset values asynchronously, no `done` pulse; the next command proceeds normally. Run with and without `SCAN_CMD_ASSERT_EN`: no assertion failures.
